// File: rtl/servo_pkg.sv
// Shared servo definitions: default timing constants, duty type, scheduler state
// encoding and the duty clamp helper.
package servo_pkg;

  localparam int unsigned SERVO_PERIOD_TICKS = 32'd240_000;
  localparam int unsigned SERVO_MIN_DUTY     = 32'd100;
  localparam int unsigned SERVO_MAX_DUTY     = 32'd200;

  typedef logic [7:0] duty_t;

  typedef enum logic [0:0] {
    AUTO   = 1'b0,
    MANUAL = 1'b1
  } sched_state_e;

  function automatic duty_t clamp_duty(input duty_t v, input duty_t lo, input duty_t hi);
    duty_t r;
    if (v < lo) begin
      r = lo;
    end else if (v > hi) begin
      r = hi;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Frame counter 0..PERIOD_TICKS; frame_end is combinational on the last tick,
// frame_start is registered and high while the counter reads 0.
module servo_frame_timer
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD_TICKS = SERVO_PERIOD_TICKS
) (
  input  logic clk,
  input  logic rst,
  output logic frame_start,
  output logic frame_end
);

  localparam int unsigned   CW   = $clog2(PERIOD_TICKS + 1);
  localparam logic [CW-1:0] LAST = CW'(PERIOD_TICKS);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] fcnt_r;

  assign frame_end = (fcnt_r == LAST);

  // Free-running frame counter; same reset as servo_pwm keeps both in lockstep.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt_r      <= '0;
      frame_start <= 1'b1;
    end else begin
      fcnt_r      <= frame_end ? '0 : fcnt_r + ONE;
      frame_start <= frame_end;
    end
  end

endmodule

// File: rtl/servo_cmd_sched.sv
// PID/host duty command arbiter with clamp, frame-synchronous slew limiting and
// host lockout. Optional command watchdog when SERVO_WDOG_EN is defined.
module servo_cmd_sched
  import servo_pkg::*;
#(
  parameter int unsigned PERIOD_TICKS = SERVO_PERIOD_TICKS,
  parameter int unsigned MIN_DUTY     = SERVO_MIN_DUTY,
  parameter int unsigned MAX_DUTY     = SERVO_MAX_DUTY,
  parameter int unsigned STEP         = 32'd4,
  parameter int unsigned HOLD_FRAMES  = 32'd50,
  parameter int unsigned WDOG_FRAMES  = 32'd25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pid_valid,
  input  logic [7:0] pid_duty,
  output logic       pid_ready,
  input  logic       host_valid,
  input  logic [7:0] host_duty,
  output logic       host_ready,
  output logic [7:0] duty_cycle,
  output logic       frame_start,
  output logic       manual,
  output logic       busy
);

  localparam duty_t            MIN_D     = duty_t'(MIN_DUTY);
  localparam duty_t            MAX_D     = duty_t'(MAX_DUTY);
  localparam logic [7:0]       STEP_8    = 8'(STEP);
  localparam int unsigned      HCW       = $clog2(HOLD_FRAMES + 1);
  localparam logic [HCW-1:0]   HOLD_LOAD = HCW'(HOLD_FRAMES);
  localparam logic [HCW-1:0]   HOLD_ONE  = HCW'(1);

  if (MIN_DUTY > MAX_DUTY || MAX_DUTY > 32'd255 || STEP < 32'd1 || STEP > 32'd255 ||
      HOLD_FRAMES < 32'd1 || WDOG_FRAMES < 32'd1) begin : g_bad_param
    $error("servo_cmd_sched: illegal parameter set");
  end

  sched_state_e   state_r;
  duty_t          target_r;
  duty_t          duty_r;
  logic [HCW-1:0] hold_r;
  logic           frame_end_s;
  logic           host_acc_s;
  logic           pid_acc_s;
  logic           wdog_fire_s;
  logic [8:0]     diff_s;
  logic [7:0]     step_amt_s;
  duty_t          slew_duty_s;

  servo_frame_timer #(.PERIOD_TICKS(PERIOD_TICKS)) u_frame_timer (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .frame_end   (frame_end_s)
  );

  assign host_ready = 1'b1;
  assign pid_ready  = (state_r == AUTO) && !host_valid;
  assign host_acc_s = host_valid;
  assign pid_acc_s  = pid_valid && pid_ready;
  assign duty_cycle = duty_r;
  assign manual     = (state_r == MANUAL);
  assign busy       = (target_r != duty_r);

  // Next slewed duty: move toward target by at most STEP; 9-bit difference cannot wrap.
  always_comb begin
    diff_s      = 9'd0;
    step_amt_s  = 8'd0;
    slew_duty_s = duty_r;
    if (target_r > duty_r) begin
      diff_s      = {1'b0, target_r} - {1'b0, duty_r};
      step_amt_s  = (diff_s > {1'b0, STEP_8}) ? STEP_8 : diff_s[7:0];
      slew_duty_s = duty_r + step_amt_s;
    end else if (target_r < duty_r) begin
      diff_s      = {1'b0, duty_r} - {1'b0, target_r};
      step_amt_s  = (diff_s > {1'b0, STEP_8}) ? STEP_8 : diff_s[7:0];
      slew_duty_s = duty_r - step_amt_s;
    end else begin
      diff_s      = 9'd0;
      step_amt_s  = 8'd0;
      slew_duty_s = duty_r;
    end
  end

`ifdef SERVO_WDOG_EN
  localparam int unsigned    WCW       = $clog2(WDOG_FRAMES + 1);
  localparam logic [WCW-1:0] WDOG_LAST = WCW'(WDOG_FRAMES - 32'd1);
  localparam logic [WCW-1:0] WDOG_MAX  = WCW'(WDOG_FRAMES);
  localparam logic [WCW-1:0] WDOG_ONE  = WCW'(1);

  logic [WCW-1:0] wdog_r;
  logic           any_acc_s;

  assign any_acc_s   = host_acc_s || pid_acc_s;
  assign wdog_fire_s = frame_end_s && !any_acc_s && (wdog_r == WDOG_LAST);

  // Saturating count of frames since the last accepted command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_r <= '0;
    end else if (any_acc_s) begin
      wdog_r <= '0;
    end else if (frame_end_s && (wdog_r != WDOG_MAX)) begin
      wdog_r <= wdog_r + WDOG_ONE;
    end
  end
`else
  assign wdog_fire_s = 1'b0;
`endif

  // Scheduler FSM: accepts, host lockout countdown and frame-boundary duty update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= AUTO;
      target_r <= MIN_D;
      duty_r   <= MIN_D;
      hold_r   <= '0;
    end else begin
      if (frame_end_s) begin
        duty_r <= slew_duty_s;
      end
      if (host_acc_s) begin
        target_r <= clamp_duty(host_duty, MIN_D, MAX_D);
        state_r  <= MANUAL;
        hold_r   <= HOLD_LOAD;
      end else if (wdog_fire_s) begin
        target_r <= MIN_D;
        state_r  <= AUTO;
        hold_r   <= '0;
      end else begin
        if (pid_acc_s) begin
          target_r <= clamp_duty(pid_duty, MIN_D, MAX_D);
        end
        if ((state_r == MANUAL) && frame_end_s) begin
          hold_r <= hold_r - HOLD_ONE;
          if (hold_r == HOLD_ONE) begin
            state_r <= AUTO;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_servo_cmd_sched.sv
// Randomized and scenario-driven bench for servo_cmd_sched against an
// integer-arithmetic reference model of the scheduling rules.
module tb_servo_cmd_sched;

  localparam int PT    = 99;
  localparam int MINV  = 100;
  localparam int MAXV  = 200;
  localparam int STEPV = 4;
  localparam int HOLDV = 50;
`ifdef SERVO_WDOG_EN
  localparam int WDOGV = 3;
`else
  localparam int WDOGV = 25;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pid_valid = 1'b0;
  logic [7:0] pid_duty = 8'd0;
  logic       pid_ready;
  logic       host_valid = 1'b0;
  logic [7:0] host_duty = 8'd0;
  logic       host_ready;
  logic [7:0] duty_cycle;
  logic       frame_start;
  logic       manual;
  logic       busy;

  int checks = 0;
  int failures = 0;

  int m_cycle, m_duty, m_target, m_hold, m_wd;
  bit m_manual;

  servo_cmd_sched #(
    .PERIOD_TICKS(PT), .MIN_DUTY(MINV), .MAX_DUTY(MAXV),
    .STEP(STEPV), .HOLD_FRAMES(HOLDV), .WDOG_FRAMES(WDOGV)
  ) dut (
    .clk(clk), .rst(rst),
    .pid_valid(pid_valid), .pid_duty(pid_duty), .pid_ready(pid_ready),
    .host_valid(host_valid), .host_duty(host_duty), .host_ready(host_ready),
    .duty_cycle(duty_cycle), .frame_start(frame_start), .manual(manual), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clampv(input int v);
    return (v < MINV) ? MINV : ((v > MAXV) ? MAXV : v);
  endfunction

  task automatic model_reset();
    m_cycle = 0; m_duty = MINV; m_target = MINV; m_hold = 0; m_wd = 0; m_manual = 1'b0;
  endtask

  // One clock: drive at negedge, predict across posedge, compare at next negedge.
  task automatic step(input bit hv, input int hd, input bit pv, input int pd);
    bit fe, pacc;
    int d;
    host_valid = hv; host_duty = hd[7:0]; pid_valid = pv; pid_duty = pd[7:0];
    #1;
    pacc = pv && !m_manual && !hv;
    chk("pid_ready", pid_ready, !m_manual && !hv);
    chk("host_ready", host_ready, 1);
    @(posedge clk);
    fe = ((m_cycle % (PT + 1)) == PT);
    if (fe) begin
      d = m_target - m_duty;
      if (d > STEPV) d = STEPV;
      if (d < -STEPV) d = -STEPV;
      m_duty += d;
    end
    if (hv) begin
      m_target = clampv(hd); m_manual = 1'b1; m_hold = HOLDV;
    end else begin
      if (pacc) m_target = clampv(pd);
      if (m_manual && fe) begin
        m_hold--;
        if (m_hold == 0) m_manual = 1'b0;
      end
    end
`ifdef SERVO_WDOG_EN
    if (hv || pacc) m_wd = 0;
    else if (fe && m_wd < WDOGV) begin
      m_wd++;
      if (m_wd == WDOGV) begin m_target = MINV; m_manual = 1'b0; m_hold = 0; end
    end
`endif
    m_cycle++;
    @(negedge clk);
    chk("duty_cycle", duty_cycle, m_duty);
    chk("frame_start", frame_start, (m_cycle % (PT + 1)) == 0);
    chk("manual", manual, m_manual);
    chk("busy", busy, m_target != m_duty);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0; host_valid = 1'b0; pid_valid = 1'b0;
    #1;
    model_reset();
    chk("rst_duty", duty_cycle, MINV);
    chk("rst_frame_start", frame_start, 1);
    chk("rst_manual", manual, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pid_ready", pid_ready, 1);
    chk("rst_host_ready", host_ready, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #2;
    do_reset();

    idle(3 * (PT + 1));
    chk("idle_duty", duty_cycle, MINV);

    step(1'b0, 0, 1'b1, 180);
    idle(21 * (PT + 1));
`ifndef SERVO_WDOG_EN
    chk("pid180_duty", duty_cycle, 180);
    chk("pid180_busy", busy, 0);
`endif

    step(1'b1, 250, 1'b1, 120);
    chk("host_manual", manual, 1);
    for (int i = 0; i < 52 * (PT + 1); i++) step(1'b0, 0, 1'b1, 120);
    chk("lockout_over", manual, 0);
    idle(30 * (PT + 1));
`ifndef SERVO_WDOG_EN
    chk("pid120_duty", duty_cycle, 120);
`endif

    for (int i = 0; i < PT + 1 && (m_cycle % (PT + 1)) != PT; i++) idle(1);
    step(1'b0, 0, 1'b1, 150);
    idle(20 * (PT + 1));

    do_reset();
    for (int i = 0; i < 20 * (PT + 1) && m_duty != 140; i++) step(1'b0, 0, 1'b1, 180);
    chk("reach140", duty_cycle, 140);
    do_reset();
    idle(5);
    chk("post_rst_duty", duty_cycle, MINV);

    step(1'b0, 0, 1'b1, 160);
    idle(25 * (PT + 1));
`ifdef SERVO_WDOG_EN
    chk("wdog_duty", duty_cycle, MINV);
`else
    chk("hold160_duty", duty_cycle, 160);
`endif

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 63) == 0, int'($urandom_range(0, 255)),
           $urandom_range(0, 3) == 0, int'($urandom_range(0, 255)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
